// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared state codes and default sequencing constants for the motoro3 line datapath.
package motoro3_pkg;
  localparam int          STEP_NUM_DEF  = 12;
  localparam logic [24:0] SPEED_MIN_DEF = 25'd64;
  localparam logic [23:0] ALIGN_CYC_DEF = 24'd1000000;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALIGN    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;
endpackage

// File: rtl/motoro3_step_index_wrap.sv
// motoro3_step_index_wrap: next commutation step (+/-1 mod STEP_NUM) and revolution wrap flag.
module motoro3_step_index_wrap import motoro3_pkg::*; #(
  parameter int STEP_NUM = STEP_NUM_DEF
) (
  input  logic [3:0] cur,
  input  logic       dir,
  output logic [3:0] nxt,
  output logic       wrap
);
  always_comb begin
    wrap = dir ? (cur == 4'd0) : (cur == 4'(STEP_NUM - 1));
    nxt  = dir ? (wrap ? 4'(STEP_NUM - 1) : cur - 4'd1) : (wrap ? 4'd0 : cur + 4'd1);
  end
endmodule

// File: rtl/motoro3_line_step_sequencer.sv
// motoro3_line_step_sequencer: run/stop FSM producing shadowed lcStep / m3LpwmStep schedule.
module motoro3_line_step_sequencer import motoro3_pkg::*; #(
  parameter int          STEP_NUM  = STEP_NUM_DEF,
  parameter logic [24:0] SPEED_MIN = SPEED_MIN_DEF,
  parameter logic [23:0] ALIGN_CYC = ALIGN_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m3r_start,
  input  logic        m3r_stop,
  input  logic        m3r_dir,
  input  logic [24:0] m3r_stepCNT_speedSET,
  input  logic [1:0]  m3r_stepSplitMax,
  output logic [3:0]  lcStep,
  output logic [1:0]  m3LpwmStep,
  output logic        seqPwmEn,
  output logic        seqBusy,
  output logic        seqStepTick,
  output logic        seqSubTick,
  output logic [15:0] seqRevCnt
);
  state_t      state, state_n;
  logic [24:0] sub_cnt, spd_sh, spd_eff;
  logic [23:0] align_cnt;
  logic [1:0]  split_sh;
  logic        dir_sh, active, sub_end, step_end, align_end, wrap;
  logic [3:0]  step_nxt;
  motoro3_step_index_wrap #(.STEP_NUM(STEP_NUM)) u_wrap (
    .cur (lcStep),
    .dir (dir_sh),
    .nxt (step_nxt),
    .wrap(wrap)
  );
  assign spd_eff   = (spd_sh < SPEED_MIN) ? SPEED_MIN : spd_sh;
  assign active    = (state == RUN) || (state == STOPPING);
  assign sub_end   = active && (sub_cnt == spd_eff - 25'd1);
  assign step_end  = sub_end && (m3LpwmStep >= split_sh);
  assign align_end = (state == ALIGN) && (align_cnt == ALIGN_CYC - 24'd1);
  assign seqBusy   = state != IDLE;
  assign seqPwmEn  = seqBusy;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)  ? ((m3r_start && !m3r_stop) ? ALIGN : IDLE) :
              (state == ALIGN) ? (m3r_stop ? IDLE : (align_end ? RUN : ALIGN)) :
              (state == RUN)   ? (m3r_stop ? STOPPING : RUN) :
                                 (step_end ? IDLE : STOPPING);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sub_cnt     <= '0;
      align_cnt   <= '0;
      spd_sh      <= '0;
      split_sh    <= '0;
      dir_sh      <= 1'b0;
      lcStep      <= '0;
      m3LpwmStep  <= '0;
      seqStepTick <= 1'b0;
      seqSubTick  <= 1'b0;
      seqRevCnt   <= '0;
    end else begin
      state       <= state_n;
      seqSubTick  <= sub_end;
      seqStepTick <= step_end;
      align_cnt   <= (state == ALIGN) ? align_cnt + 24'd1 : 24'd0;
      sub_cnt     <= (active && !sub_end) ? sub_cnt + 25'd1 : 25'd0;
      if (state == IDLE) begin
        lcStep     <= '0;
        m3LpwmStep <= '0;
      end
      if (state == IDLE && state_n == ALIGN)
        seqRevCnt <= '0;
      else if (step_end && wrap)
        seqRevCnt <= seqRevCnt + 16'd1;
      // split is only reloaded here, where m3LpwmStep returns to 0, so it can never exceed split_sh
      if (align_end || step_end) begin
        spd_sh   <= m3r_stepCNT_speedSET;
        split_sh <= m3r_stepSplitMax;
        dir_sh   <= m3r_dir;
      end
      if (step_end) begin
        lcStep     <= step_nxt;
        m3LpwmStep <= '0;
      end else if (sub_end) begin
        m3LpwmStep <= m3LpwmStep + 2'd1;
      end
    end
  end
endmodule
